fifo_event_reader: RTL and testbench
====================================

// Module: fifo_event_reader
// PURPOSE
// Consumer end of the global event FIFO filled by the multi-channel digitizer.
// Pops words, decodes each header word {1'b0, CHAN[2:0], BC[11:0]}, strips it, and
// forwards the following HOWMANY sample words as a framed valid/ready stream
// tagged with channel and BC, toward the Zynq-side readout. Replaces the raw
// ZYNQ_RD_REQUEST pop path and keeps event and error counters.
// PARAMETERS
// WIDTH     16  FIFO word / sample width; header layout is fixed for 16.
// SIZE      8   width of HOWMANY (same value programmed into the channels).
// CHAN_BITS 3   channel field width, header bits [14:12].
// BC_BITS   12  bunch-crossing field width, header bits [11:0].
// PORTS
// CLK          in   1          system clock (CK50 domain).
// RST_N        in   1          asynchronous active-low reset.
// HOWMANY      in   SIZE       samples per event after each header; static while BUSY.
// FIFO_DOUT    in   WIDTH      global FIFO read data; valid 1 cycle after a pop.
// FIFO_EMPTY   in   1          global FIFO empty flag.
// FIFO_RD_EN   out  1          pop strobe to global FIFO.
// M_DATA       out  WIDTH      sample word.
// M_CHAN       out  CHAN_BITS  channel of current event.
// M_BC         out  BC_BITS    BC of current event.
// M_SOF        out  1          first sample of event.
// M_EOF        out  1          last sample of event.
// M_VALID      out  1          output beat valid.
// M_READY      in   1          downstream accepts beat.
// BUSY         out  1          high whenever state != IDLE or a pop is in flight.
// EVT_CNT      out  16         completed events, wraps 0xFFFF->0.
// ERR_CNT      out  8          bad-header words dropped, saturates at 0xFF.
// BEHAVIOUR
// - Reset (async, RST_N=0): all outputs 0, state IDLE, counters 0, in-flight flag 0.
//   A pop in flight at reset is discarded; reset release synchronous to CLK.
// - Pop rule: FIFO_RD_EN = !FIFO_EMPTY && !inflight && (!M_VALID || M_READY).
//   At most one pop in flight; inflight set on pop, cleared next cycle when word lands.
//   Max throughput 1 word / 2 cycles. FIFO_RD_EN never high while FIFO_EMPTY=1.
// - Landed word handled per state:
//   IDLE: bit15=0 -> latch M_CHAN<=[14:12], M_BC<=[11:0], cnt<=0;
//         HOWMANY==0 -> EVT_CNT++, stay IDLE (header-only event, no beats);
//         else -> DATA. bit15=1 -> word dropped, ERR_CNT++ (sat), stay IDLE.
//   DATA: word -> M_DATA, M_VALID<=1, M_SOF<=(cnt==0), M_EOF<=(cnt==HOWMANY-1),
//         cnt++. On the EOF word -> EVT_CNT++, state IDLE. Sample words are not
//         header-checked (any bit15 accepted).
// - Output hold: M_DATA/M_SOF/M_EOF/M_CHAN/M_BC stable while M_VALID && !M_READY.
//   M_VALID drops the cycle after acceptance unless a new word lands that cycle.
//   M_CHAN/M_BC update only on header; held through all beats of the event.
// - Latency: FIFO_RD_EN of a sample -> M_VALID on the 2nd following edge (1 FIFO + 1 reg).
// - cnt is SIZE bits; HOWMANY=2^SIZE-1 is the max event length; no wrap inside an event.
// - FIFO empty mid-event: stay in DATA, resume when words arrive; no timeout.
// - Back-to-back events: next header may land in the cycle after EOF beat issues.
// TESTING
// 1 Reset: RST_N low mid-event with M_VALID=1 -> all outputs 0 immediately; next
//   header after release decodes normally.
// 2 HOWMANY=3, FIFO {0x5ABC,0x0011,0x8022,0x0033}, M_READY=1 -> 3 beats CHAN=5
//   BC=0xABC, SOF on 0x0011, EOF on 0x0033, EVT_CNT=1.
// 3 Backpressure: same event, M_READY low 5 cycles on beat 2 -> beat held stable,
//   no FIFO_RD_EN while held, no words lost or duplicated.
// 4 Bad header: FIFO {0x8000, 0x2001, 4 samples} HOWMANY=4 -> ERR_CNT=1, one event
//   CHAN=2 BC=0x001, 4 beats.
// 5 HOWMANY=0, three headers -> no beats, EVT_CNT=3, FIFO_RD_EN never with EMPTY=1.
// 6 EVT_CNT preset via 65536 header-only events -> wraps to 0; 300 bad words -> ERR_CNT=0xFF.

Source files
------------

// File: rtl/fifo_event_reader.sv
// rtl/fifo_event_reader.sv - global event FIFO consumer: header decode, framed sample stream, counters
// Pops one word at a time, strips headers and forwards HOWMANY tagged samples per event.
module fifo_event_reader #(
    parameter int WIDTH     = 16,
    parameter int SIZE      = 8,
    parameter int CHAN_BITS = 3,
    parameter int BC_BITS   = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [SIZE-1:0]      howmany_i,
    input  logic [WIDTH-1:0]     fifo_dout_i,
    input  logic                 fifo_empty_i,
    output logic                 fifo_rd_en_o,
    output logic [WIDTH-1:0]     m_data_o,
    output logic [CHAN_BITS-1:0] m_chan_o,
    output logic [BC_BITS-1:0]   m_bc_o,
    output logic                 m_sof_o,
    output logic                 m_eof_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic                 busy_o,
    output logic [15:0]          evt_cnt_o,
    output logic [7:0]           err_cnt_o
);

    typedef enum logic {S_IDLE, S_DATA} state_t;

    localparam logic [SIZE-1:0] ONE = {{(SIZE-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic                 inflight_q, inflight_d;
    logic [SIZE-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [CHAN_BITS-1:0] chan_q, chan_d;
    logic [BC_BITS-1:0]   bc_q, bc_d;
    logic                 sof_q, sof_d;
    logic                 eof_q, eof_d;
    logic                 valid_q, valid_d;
    logic [15:0]          evt_q, evt_d;
    logic [7:0]           err_q, err_d;
    logic                 pop;
    logic                 last;

    // Gating with rst_n_i keeps the strobe low while reset is held.
    assign pop  = rst_n_i && !fifo_empty_i && !inflight_q && (!valid_q || m_ready_i);
    assign last = (cnt_q == howmany_i - ONE);

    always_comb begin
        state_d    = state_q;
        inflight_d = pop;
        cnt_d      = cnt_q;
        data_d     = data_q;
        chan_d     = chan_q;
        bc_d       = bc_q;
        sof_d      = sof_q;
        eof_d      = eof_q;
        valid_d    = valid_q;
        evt_d      = evt_q;
        err_d      = err_q;

        if (valid_q && m_ready_i) begin
            valid_d = 1'b0;
        end

        // A word popped last cycle is on fifo_dout_i now.
        if (inflight_q) begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_dout_i[WIDTH-1]) begin
                        chan_d = fifo_dout_i[CHAN_BITS+BC_BITS-1:BC_BITS];
                        bc_d   = fifo_dout_i[BC_BITS-1:0];
                        cnt_d  = '0;
                        if (howmany_i == '0) begin
                            evt_d = evt_q + 16'd1;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                end
                S_DATA: begin
                    data_d  = fifo_dout_i;
                    valid_d = 1'b1;
                    sof_d   = (cnt_q == '0);
                    eof_d   = last;
                    cnt_d   = cnt_q + ONE;
                    if (last) begin
                        evt_d   = evt_q + 16'd1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
            data_q     <= '0;
            chan_q     <= '0;
            bc_q       <= '0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            valid_q    <= 1'b0;
            evt_q      <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            chan_q     <= chan_d;
            bc_q       <= bc_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            valid_q    <= valid_d;
            evt_q      <= evt_d;
            err_q      <= err_d;
        end
    end

    assign fifo_rd_en_o = pop;
    assign m_data_o     = data_q;
    assign m_chan_o     = chan_q;
    assign m_bc_o       = bc_q;
    assign m_sof_o      = sof_q;
    assign m_eof_o      = eof_q;
    assign m_valid_o    = valid_q;
    assign busy_o       = (state_q != S_IDLE) || inflight_q;
    assign evt_cnt_o    = evt_q;
    assign err_cnt_o    = err_q;

endmodule

// File: tb/tb_fifo_event_reader.sv
// tb/tb_fifo_event_reader.sv - directed bench for fifo_event_reader
// A simple FIFO model feeds the DUT; a negedge monitor records beats and protocol violations.
module tb_fifo_event_reader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  howmany;
    logic [15:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] m_data;
    logic [2:0]  m_chan;
    logic [11:0] m_bc;
    logic        m_sof;
    logic        m_eof;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic [15:0] evt_cnt;
    logic [7:0]  err_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;

    logic [32:0] beats [0:63];
    int nbeats     = 0;
    int empty_viol = 0;
    int hold_pop   = 0;
    int hold_err   = 0;
    logic        held_q = 1'b0;
    logic [32:0] held_v = '0;

    fifo_event_reader dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .howmany_i    (howmany),
        .fifo_dout_i  (fifo_dout),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_en_o (fifo_rd_en),
        .m_data_o     (m_data),
        .m_chan_o     (m_chan),
        .m_bc_o       (m_bc),
        .m_sof_o      (m_sof),
        .m_eof_o      (m_eof),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .busy_o       (busy),
        .evt_cnt_o    (evt_cnt),
        .err_cnt_o    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= mem[rd_ptr % 1024];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            held_q <= 1'b0;
        end else begin
            if (fifo_rd_en && fifo_empty) empty_viol <= empty_viol + 1;
            if (fifo_rd_en && m_valid && !m_ready) hold_pop <= hold_pop + 1;
            if (held_q && (!m_valid || {m_data, m_chan, m_bc, m_sof, m_eof} != held_v))
                hold_err <= hold_err + 1;
            held_q <= m_valid && !m_ready;
            held_v <= {m_data, m_chan, m_bc, m_sof, m_eof};
            if (m_valid && m_ready && nbeats < 64) begin
                beats[nbeats] <= {m_data, m_chan, m_bc, m_sof, m_eof};
                nbeats        <= nbeats + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        mem[wr_ptr % 1024] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input int idx, input logic [15:0] d,
                              input logic [2:0] ch, input logic [11:0] bc,
                              input logic sof, input logic eof);
        check(tag, 64'(beats[idx]), 64'({d, ch, bc, sof, eof}));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        while (!done && n < budget) begin
            step();
            done = fifo_empty && !busy && !m_valid;
            n++;
        end
        check({tag, "_timeout"}, 64'(done), 64'd1);
    endtask

    initial begin
        int  base;
        int  n;
        bit  found;

        rst_n   = 1'b0;
        howmany = 8'd3;
        m_ready = 1'b1;
        repeat (3) step();

        check("reset_valid", 64'(m_valid), 64'd0);
        check("reset_rd_en", 64'(fifo_rd_en), 64'd0);
        check("reset_cnts", 64'({evt_cnt, err_cnt, busy}), 64'd0);

        rst_n = 1'b1;
        step();

        // Plain event with a bit15-set sample in the middle.
        base = nbeats;
        push(16'h5ABC); push(16'h0011); push(16'h8022); push(16'h0033);
        wait_idle("t2", 100);
        check("t2_nbeats", 64'(nbeats - base), 64'd3);
        check_beat("t2_b0", base + 0, 16'h0011, 3'd5, 12'hABC, 1'b1, 1'b0);
        check_beat("t2_b1", base + 1, 16'h8022, 3'd5, 12'hABC, 1'b0, 1'b0);
        check_beat("t2_b2", base + 2, 16'h0033, 3'd5, 12'hABC, 1'b0, 1'b1);
        check("t2_evt", 64'(evt_cnt), 64'd1);

        // Same event, beat 2 stalled for five cycles.
        base = nbeats;
        push(16'h5ABC); push(16'h0011); push(16'h8022); push(16'h0033);
        found = 0;
        n     = 0;
        while (!found && n < 50) begin
            step();
            if (m_valid && m_data == 16'h8022) begin
                m_ready = 1'b0;
                found   = 1;
            end
            n++;
        end
        check("t3_stall_seen", 64'(found), 64'd1);
        repeat (5) step();
        check("t3_still_held", 64'({m_valid, m_data}), 64'({1'b1, 16'h8022}));
        m_ready = 1'b1;
        wait_idle("t3", 100);
        check("t3_nbeats", 64'(nbeats - base), 64'd3);
        check_beat("t3_b0", base + 0, 16'h0011, 3'd5, 12'hABC, 1'b1, 1'b0);
        check_beat("t3_b1", base + 1, 16'h8022, 3'd5, 12'hABC, 1'b0, 1'b0);
        check_beat("t3_b2", base + 2, 16'h0033, 3'd5, 12'hABC, 1'b0, 1'b1);
        check("t3_hold_err", 64'(hold_err), 64'd0);
        check("t3_hold_pop", 64'(hold_pop), 64'd0);
        check("t3_evt", 64'(evt_cnt), 64'd2);

        // Bad header dropped, then a normal four-sample event.
        howmany = 8'd4;
        base = nbeats;
        push(16'h8000); push(16'h2001);
        push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
        wait_idle("t4", 100);
        check("t4_err", 64'(err_cnt), 64'd1);
        check("t4_evt", 64'(evt_cnt), 64'd3);
        check("t4_nbeats", 64'(nbeats - base), 64'd4);
        check_beat("t4_b0", base + 0, 16'h1111, 3'd2, 12'h001, 1'b1, 1'b0);
        check_beat("t4_b1", base + 1, 16'h2222, 3'd2, 12'h001, 1'b0, 1'b0);
        check_beat("t4_b2", base + 2, 16'h3333, 3'd2, 12'h001, 1'b0, 1'b0);
        check_beat("t4_b3", base + 3, 16'h4444, 3'd2, 12'h001, 1'b0, 1'b1);

        // Header-only events.
        howmany = 8'd0;
        base = nbeats;
        push(16'h1001); push(16'h2002); push(16'h3003);
        wait_idle("t5", 100);
        check("t5_nbeats", 64'(nbeats - base), 64'd0);
        check("t5_evt", 64'(evt_cnt), 64'd6);
        check("t5_chan_bc", 64'({m_chan, m_bc}), 64'({3'd3, 12'h003}));
        check("t5_empty_viol", 64'(empty_viol), 64'd0);

        // Reset asserted while a beat is held.
        howmany = 8'd3;
        m_ready = 1'b0;
        push(16'h7123); push(16'h0001); push(16'h0002); push(16'h0003);
        found = 0;
        n     = 0;
        while (!found && n < 50) begin
            step();
            found = m_valid;
            n++;
        end
        check("t1_valid_before", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t1_rst_stream", 64'({m_valid, m_data, m_chan, m_bc, m_sof, m_eof}), 64'd0);
        check("t1_rst_misc", 64'({fifo_rd_en, busy, evt_cnt, err_cnt}), 64'd0);
        wr_ptr = rd_ptr;
        m_ready = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        base = nbeats;
        push(16'h6456); push(16'h000A); push(16'h000B); push(16'h000C);
        wait_idle("t1", 100);
        check("t1_nbeats", 64'(nbeats - base), 64'd3);
        check_beat("t1_b0", base + 0, 16'h000A, 3'd6, 12'h456, 1'b1, 1'b0);
        check_beat("t1_b2", base + 2, 16'h000C, 3'd6, 12'h456, 1'b0, 1'b1);
        check("t1_evt", 64'(evt_cnt), 64'd1);

        // Counter wrap and saturation.
        howmany = 8'd0;
        force dut.evt_q = 16'hFFFE;
        #1;
        release dut.evt_q;
        push(16'h1000); push(16'h1001);
        wait_idle("t6a", 100);
        check("t6_evt_wrap", 64'(evt_cnt), 64'd0);
        for (int i = 0; i < 300; i++) push(16'hFFFF);
        wait_idle("t6b", 1000);
        check("t6_err_sat", 64'(err_cnt), 64'hFF);
        for (int i = 0; i < 5; i++) push(16'h8001);
        wait_idle("t6c", 100);
        check("t6_err_hold", 64'(err_cnt), 64'hFF);
        check("t6_evt_after", 64'(evt_cnt), 64'd0);
        check("end_empty_viol", 64'(empty_viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
